// File: rtl/rv32imc_1p_wb_if.sv
// rv32imc_1p_wb_if: result-source handshakes, scoreboard queries and register-file write port
interface rv32imc_1p_wb_if #(parameter int XLEN = 32);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_dat;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_dat;
    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_dat;
    logic            iss_long;
    logic [4:0]      iss_rd;
    logic [4:0]      rs1_addr;
    logic            rs1_busy;
    logic [4:0]      rs2_addr;
    logic            rs2_busy;
    logic            c_rf_write;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_dati;
    logic            wb_err;
    modport slave (
        input  alu_valid, alu_rd, alu_dat, lsu_valid, lsu_rd, lsu_dat,
               md_valid, md_rd, md_dat, iss_long, iss_rd, rs1_addr, rs2_addr,
        output lsu_ready, md_ready, rs1_busy, rs2_busy, c_rf_write, rd_addr, rd_dati, wb_err
    );
    modport master (
        output alu_valid, alu_rd, alu_dat, lsu_valid, lsu_rd, lsu_dat,
               md_valid, md_rd, md_dat, iss_long, iss_rd, rs1_addr, rs2_addr,
        input  lsu_ready, md_ready, rs1_busy, rs2_busy, c_rf_write, rd_addr, rd_dati, wb_err
    );
endinterface

// File: rtl/rv32imc_1p_wb.sv
// rv32imc_1p_wb: write-back arbiter (ALU > round-robin LSU/MUL-DIV) with long-latency pending scoreboard
module rv32imc_1p_wb #(
    parameter int NREG = 16,
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst_n,
    rv32imc_1p_wb_if.slave bus
);
    typedef enum logic {RR_LSU, RR_MD} rr_t;
    rr_t             rr, rr_nxt;
    logic            lsu_gnt, md_gnt, acc, we, long_wr, err;
    logic [4:0]      win_rd, rd_q;
    logic [XLEN-1:0] win_dat, dat_q;
    logic [NREG-1:0] pending, pend_nxt;
    always_comb begin
        lsu_gnt  = rst_n && !bus.alu_valid && bus.lsu_valid && (!bus.md_valid || rr == RR_LSU);
        md_gnt   = rst_n && !bus.alu_valid && bus.md_valid && (!bus.lsu_valid || rr == RR_MD);
        acc      = (rst_n && bus.alu_valid) || lsu_gnt || md_gnt;
        win_rd   = bus.alu_valid ? bus.alu_rd : lsu_gnt ? bus.lsu_rd : bus.md_rd;
        win_dat  = bus.alu_valid ? bus.alu_dat : lsu_gnt ? bus.lsu_dat : bus.md_dat;
        rr_nxt   = lsu_gnt ? RR_MD : md_gnt ? RR_LSU : rr;
        pend_nxt = pending;
        if (we && long_wr)
            pend_nxt[rd_q[3:0]] = 1'b0;
        // a new issue to the same register outranks the retiring write
        if (bus.iss_long && bus.iss_rd != 5'd0 && !bus.iss_rd[4])
            pend_nxt[bus.iss_rd[3:0]] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr      <= RR_LSU;
            we      <= 1'b0;
            long_wr <= 1'b0;
            rd_q    <= '0;
            dat_q   <= '0;
            pending <= '0;
            err     <= 1'b0;
        end else begin
            rr      <= rr_nxt;
            we      <= acc && win_rd != 5'd0 && !win_rd[4];
            long_wr <= !bus.alu_valid;
            pending <= pend_nxt;
            err     <= err || (acc && win_rd[4]);
            if (acc) begin
                rd_q  <= win_rd;
                dat_q <= win_dat;
            end
        end
    end
    assign bus.lsu_ready  = lsu_gnt;
    assign bus.md_ready   = md_gnt;
    assign bus.c_rf_write = we;
    assign bus.rd_addr    = rd_q;
    assign bus.rd_dati    = dat_q;
    assign bus.wb_err     = err;
    assign bus.rs1_busy   = bus.rs1_addr != 5'd0 && !bus.rs1_addr[4] && pending[bus.rs1_addr[3:0]];
    assign bus.rs2_busy   = bus.rs2_addr != 5'd0 && !bus.rs2_addr[4] && pending[bus.rs2_addr[3:0]];
endmodule

// File: tb/tb_rv32imc_1p_wb.sv
// tb_rv32imc_1p_wb: directed scenarios plus randomized traffic against a behavioural write-back model
module tb_rv32imc_1p_wb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv32imc_1p_wb_if #(.XLEN(32)) bus ();
    rv32imc_1p_wb #(.NREG(16), .XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_dat = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_dat = 0;
        bus.md_valid = 0;  bus.md_rd = 0;  bus.md_dat = 0;
        bus.iss_long = 0;  bus.iss_rd = 0;
        bus.rs1_addr = 0;  bus.rs2_addr = 0;
    endtask

    function automatic logic [4:0] pick_rd();
        return ($urandom_range(0, 40) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 15));
    endfunction

    task automatic test_reset();
        idle();
        rst_n = 0;
        bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_dat = 32'h55;
        bus.rs1_addr = 3;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready got %b exp 0", bus.lsu_ready); end
            checks++; if (bus.c_rf_write !== 1'b0) begin errors++; $display("FAIL reset_c_rf_write got %b exp 0", bus.c_rf_write); end
            checks++; if (bus.rd_addr !== 5'd0 || bus.rd_dati !== 32'd0) begin errors++; $display("FAIL reset_rd got %0d/%h exp 0/0", bus.rd_addr, bus.rd_dati); end
            checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy got %b exp 0", bus.rs1_busy); end
            checks++; if (bus.wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b exp 0", bus.wb_err); end
        end
        idle();
        rst_n = 1;
        step();
    endtask

    task automatic test_alu();
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_dat = 32'hDEADBEEF;
        step();
        bus.alu_valid = 0;
        #1;
        checks++; if (bus.c_rf_write !== 1'b1) begin errors++; $display("FAIL alu_we got %b exp 1", bus.c_rf_write); end
        checks++; if (bus.rd_addr !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d exp 5", bus.rd_addr); end
        checks++; if (bus.rd_dati !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_dat got %h exp deadbeef", bus.rd_dati); end
        step();
        checks++; if (bus.c_rf_write !== 1'b0) begin errors++; $display("FAIL alu_we_drop got %b exp 0", bus.c_rf_write); end
    endtask

    task automatic test_priority();
        bus.alu_valid = 1; bus.alu_rd = 6; bus.alu_dat = 32'hAA;
        bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_dat = 32'h11;
        bus.md_valid = 1;  bus.md_rd = 4;  bus.md_dat = 32'h22;
        #1;
        checks++; if (bus.lsu_ready !== 1'b0 || bus.md_ready !== 1'b0) begin errors++; $display("FAIL prio_alu_block got %b%b exp 00", bus.lsu_ready, bus.md_ready); end
        step();
        bus.alu_valid = 0;
        #1;
        checks++; if (bus.c_rf_write !== 1'b1 || bus.rd_addr !== 5'd6 || bus.rd_dati !== 32'hAA) begin errors++; $display("FAIL prio_alu_wr got %b/%0d/%h exp 1/6/aa", bus.c_rf_write, bus.rd_addr, bus.rd_dati); end
        checks++; if (bus.lsu_ready !== 1'b1 || bus.md_ready !== 1'b0) begin errors++; $display("FAIL prio_lsu_first got %b%b exp 10", bus.lsu_ready, bus.md_ready); end
        step();
        bus.lsu_valid = 0;
        #1;
        checks++; if (bus.c_rf_write !== 1'b1 || bus.rd_addr !== 5'd3 || bus.rd_dati !== 32'h11) begin errors++; $display("FAIL prio_lsu_wr got %b/%0d/%h exp 1/3/11", bus.c_rf_write, bus.rd_addr, bus.rd_dati); end
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL prio_md_second got %b exp 1", bus.md_ready); end
        step();
        bus.md_valid = 0;
        #1;
        checks++; if (bus.c_rf_write !== 1'b1 || bus.rd_addr !== 5'd4 || bus.rd_dati !== 32'h22) begin errors++; $display("FAIL prio_md_wr got %b/%0d/%h exp 1/4/22", bus.c_rf_write, bus.rd_addr, bus.rd_dati); end
        step();
        checks++; if (bus.c_rf_write !== 1'b0) begin errors++; $display("FAIL prio_idle got %b exp 0", bus.c_rf_write); end
    endtask

    task automatic test_scoreboard();
        bus.iss_long = 1; bus.iss_rd = 7;
        step();
        bus.iss_long = 0; bus.rs1_addr = 7;
        #1;
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set got %b exp 1", bus.rs1_busy); end
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_dat = 32'h1234;
        #1;
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL sb_lsu_ready got %b exp 1", bus.lsu_ready); end
        step();
        bus.lsu_valid = 0;
        #1;
        checks++; if (bus.c_rf_write !== 1'b1 || bus.rd_dati !== 32'h1234) begin errors++; $display("FAIL sb_wr got %b/%h exp 1/1234", bus.c_rf_write, bus.rd_dati); end
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_in_wr got %b exp 1", bus.rs1_busy); end
        step();
        checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear got %b exp 0", bus.rs1_busy); end
        bus.rs1_addr = 0;
    endtask

    task automatic test_collision();
        bus.iss_long = 1; bus.iss_rd = 9;
        step();
        bus.iss_long = 0;
        bus.md_valid = 1; bus.md_rd = 9; bus.md_dat = 32'h99;
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL col_md_ready got %b exp 1", bus.md_ready); end
        step();
        bus.md_valid = 0; bus.iss_long = 1; bus.iss_rd = 9; bus.rs2_addr = 9;
        #1;
        checks++; if (bus.c_rf_write !== 1'b1 || bus.rd_addr !== 5'd9) begin errors++; $display("FAIL col_wr got %b/%0d exp 1/9", bus.c_rf_write, bus.rd_addr); end
        step();
        bus.iss_long = 0;
        #1;
        checks++; if (bus.rs2_busy !== 1'b1) begin errors++; $display("FAIL col_set_wins got %b exp 1", bus.rs2_busy); end
        step();
        checks++; if (bus.rs2_busy !== 1'b1) begin errors++; $display("FAIL col_hold got %b exp 1", bus.rs2_busy); end
        bus.rs2_addr = 0;
    endtask

    task automatic test_illegal();
        bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_dat = 32'h77;
        #1;
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", bus.lsu_ready); end
        step();
        bus.lsu_valid = 0;
        #1;
        checks++; if (bus.c_rf_write !== 1'b0 || bus.wb_err !== 1'b0) begin errors++; $display("FAIL zero_nowrite got we=%b err=%b exp 0/0", bus.c_rf_write, bus.wb_err); end
        bus.md_valid = 1; bus.md_rd = 17; bus.md_dat = 32'h88;
        #1;
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got %b exp 1", bus.md_ready); end
        step();
        bus.md_valid = 0;
        #1;
        checks++; if (bus.c_rf_write !== 1'b0 || bus.wb_err !== 1'b1) begin errors++; $display("FAIL ill_err got we=%b err=%b exp 0/1", bus.c_rf_write, bus.wb_err); end
        repeat (3) step();
        checks++; if (bus.wb_err !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b exp 1", bus.wb_err); end
        rst_n = 0;
        step();
        rst_n = 1;
        checks++; if (bus.wb_err !== 1'b0 || bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL ill_reset got err=%b busy=%b exp 0/0", bus.wb_err, bus.rs2_busy); end
    endtask

    task automatic test_random();
        bit          pend [16];
        bit          pref_md, s_we, s_long, err, g_l, g_m, acc, b1, b2;
        logic [4:0]  s_rd, a_rd;
        logic [31:0] s_dat, a_dat;
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
        foreach (pend[i]) pend[i] = 0;
        pref_md = 0; s_we = 0; s_long = 0; err = 0; s_rd = 0; s_dat = 0; g_l = 0; g_m = 0;
        for (int c = 0; c < 3000; c++) begin
            if (g_l) bus.lsu_valid = 0;
            if (g_m) bus.md_valid = 0;
            bus.alu_valid = ($urandom_range(0, 3) == 0);
            bus.alu_rd = pick_rd(); bus.alu_dat = $urandom;
            if (!bus.lsu_valid && $urandom_range(0, 1) == 1) begin bus.lsu_valid = 1; bus.lsu_rd = pick_rd(); bus.lsu_dat = $urandom; end
            if (!bus.md_valid && $urandom_range(0, 1) == 1) begin bus.md_valid = 1; bus.md_rd = pick_rd(); bus.md_dat = $urandom; end
            bus.iss_long = ($urandom_range(0, 2) == 0); bus.iss_rd = pick_rd();
            bus.rs1_addr = pick_rd(); bus.rs2_addr = pick_rd();
            #1;
            g_l = !bus.alu_valid && bus.lsu_valid && (!bus.md_valid || !pref_md);
            g_m = !bus.alu_valid && bus.md_valid && (!bus.lsu_valid || pref_md);
            b1 = bus.rs1_addr != 0 && bus.rs1_addr < 16 && pend[bus.rs1_addr[3:0]];
            b2 = bus.rs2_addr != 0 && bus.rs2_addr < 16 && pend[bus.rs2_addr[3:0]];
            checks++; if (bus.lsu_ready !== g_l || bus.md_ready !== g_m) begin errors++; $display("FAIL rnd_ready c=%0d got %b%b exp %b%b", c, bus.lsu_ready, bus.md_ready, g_l, g_m); end
            checks++; if (bus.c_rf_write !== s_we) begin errors++; $display("FAIL rnd_we c=%0d got %b exp %b", c, bus.c_rf_write, s_we); end
            if (s_we) begin
                checks++; if (bus.rd_addr !== s_rd || bus.rd_dati !== s_dat) begin errors++; $display("FAIL rnd_wr c=%0d got %0d/%h exp %0d/%h", c, bus.rd_addr, bus.rd_dati, s_rd, s_dat); end
            end
            checks++; if (bus.rs1_busy !== b1 || bus.rs2_busy !== b2) begin errors++; $display("FAIL rnd_busy c=%0d got %b%b exp %b%b", c, bus.rs1_busy, bus.rs2_busy, b1, b2); end
            checks++; if (bus.wb_err !== err) begin errors++; $display("FAIL rnd_err c=%0d got %b exp %b", c, bus.wb_err, err); end
            acc   = bus.alu_valid || g_l || g_m;
            a_rd  = bus.alu_valid ? bus.alu_rd : g_l ? bus.lsu_rd : bus.md_rd;
            a_dat = bus.alu_valid ? bus.alu_dat : g_l ? bus.lsu_dat : bus.md_dat;
            if (s_we && s_long) pend[s_rd[3:0]] = 0;
            if (bus.iss_long && bus.iss_rd != 0 && bus.iss_rd < 16) pend[bus.iss_rd[3:0]] = 1;
            if (acc && a_rd >= 16) err = 1;
            s_we = acc && a_rd != 0 && a_rd < 16;
            s_long = !bus.alu_valid;
            if (acc) begin s_rd = a_rd; s_dat = a_dat; end
            if (g_l || g_m) pref_md = g_l;
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_alu();
        test_priority();
        test_scoreboard();
        test_collision();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32imc_1p_wb.md
Name: rv32imc_1p_wb

Overview:
- Write-back unit driving the single register-file write port: c_rf_write, rd_addr, rd_dati.
- Arbitrates three result sources: ALU (single-cycle), LSU load return and MUL/DIV return, and registers the winning result.
- Keeps a 16-entry pending scoreboard for long-latency destinations so the decode stage can stall reads of registers not yet written.
- Sits between the execute/memory units and the register file.

Parameters:
- NREG, 16, number of architectural registers tracked (RV32E-sized file).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  ALU destination.
- alu_dat  in  XLEN  ALU result.
- lsu_valid  in  1  load result offered.
- lsu_ready  out  1  load result accepted this cycle.
- lsu_rd  in  5  load destination.
- lsu_dat  in  XLEN  load data.
- md_valid  in  1  MUL/DIV result offered.
- md_ready  out  1  MUL/DIV result accepted this cycle.
- md_rd  in  5  MUL/DIV destination.
- md_dat  in  XLEN  MUL/DIV result.
- iss_long  in  1  long-latency (load or MUL/DIV) instruction issued this cycle.
- iss_rd  in  5  destination of the issued instruction.
- rs1_addr  in  5  decode query address 1.
- rs1_busy  out  1  rs1_addr has an outstanding long-latency write.
- rs2_addr  in  5  decode query address 2.
- rs2_busy  out  1  rs2_addr has an outstanding long-latency write.
- c_rf_write  out  1  register-file write enable.
- rd_addr  out  5  register-file write address.
- rd_dati  out  XLEN  register-file write data.
- wb_err  out  1  sticky illegal-destination flag.

Behaviour:
- Reset (rst_n=0 at posedge): c_rf_write=0, rd_addr=0, rd_dati=0, pending=0, wb_err=0, round-robin pointer selects LSU first. lsu_ready and md_ready are 0 while rst_n=0.
- Acceptance is combinational on the valid/ready handshake. A result accepted in cycle N appears on c_rf_write/rd_addr/rd_dati in cycle N+1, for exactly one cycle. The register file is updated at the end of N+1.
- Priority: ALU is highest.
  - alu_valid=1 forces lsu_ready=0 and md_ready=0.
  - With no ALU result, exactly one of lsu/md is granted when both are valid. Round-robin: the pointer toggles to the other source after each grant to either source.
  - A single valid source is always granted.
- LSU/MUL-DIV sources hold valid and data stable until ready.
- A destination of 0 is still accepted (handshake completes), but c_rf_write stays 0 in N+1.
- A destination with bit4=1 is illegal (only 16 registers exist):
  - accepted;
  - no write;
  - wb_err set, cleared only by reset.
- Scoreboard pending[15:0]:
  - Set: iss_long=1 and iss_rd in 1..15 sets pending[iss_rd] at the next edge.
  - Clear: pending[rd_addr] is cleared at the edge ending a cycle where c_rf_write=1 from an LSU/MUL-DIV grant. This is the same edge that writes the register file.
  - Set and clear of the same index on the same edge: set wins (new outstanding write).
  - ALU writes never touch pending.
- Busy query:
  - rsX_busy = pending[rsX_addr[3:0]], combinational.
  - Forced to 0 when rsX_addr==0 or rsX_addr[4]=1.
  - During the c_rf_write cycle the register still reads busy; it is free the following cycle, when the file holds the new value.
- Reset mid-operation: in-flight staged write dropped (c_rf_write=0 next cycle), pending cleared, no handshake completes while rst_n=0.

Test Plan:
- Reset: hold rst_n=0 two cycles with lsu_valid=1 → lsu_ready=0, c_rf_write=0, rs1_busy=0, wb_err=0.
- ALU path: alu_valid=1, alu_rd=5, alu_dat=0xDEADBEEF at cycle N → cycle N+1: c_rf_write=1, rd_addr=5, rd_dati=0xDEADBEEF; cycle N+2: c_rf_write=0.
- Priority/fairness: alu, lsu(rd=3, 0x11) and md(rd=4, 0x22) all valid continuously for 1 cycle, then ALU drops → ALU written first; then LSU and MD granted on alternate cycles, order LSU then MD; no ready while alu_valid=1.
- Scoreboard: iss_long=1, iss_rd=7 → next cycle rs1_addr=7 gives rs1_busy=1. lsu_valid, rd=7, 0x1234 accepted at N → busy still 1 in N+1 (write cycle), 0 in N+2.
- Set/clear collision: MD write to rd=9 in the c_rf_write cycle while iss_long=1, iss_rd=9 → rs2_busy for 9 remains 1 afterwards.
- Illegal/zero destination: lsu_rd=0 → ready=1, no write, no error. md_rd=17 → ready=1, no write, wb_err=1 and stays 1 until rst_n=0.
